// File: rtl/axi_rw_arbiter.sv
// Burst-granular round-robin arbiter sharing one RAM port between the AXI write and read paths.
// Optional grant statistics counters are built when AXI_RW_ARB_STATS_EN is defined.
module axi_rw_arbiter #(
    parameter int LEN_WIDTH  = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    input  logic                  wr_beat,
    input  logic                  rd_req,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    input  logic                  rd_beat,
    output logic                  aw_ready,
    output logic                  ar_ready,
    output logic                  grant_wr,
    output logic                  grant_rd,
    output logic                  last_grant,
    output logic                  proto_err,
    output logic [STAT_WIDTH-1:0] wr_grant_cnt,
    output logic [STAT_WIDTH-1:0] rd_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t               state_reg;
    logic [LEN_WIDTH-1:0] beat_cnt_reg;
    logic                 start_wr;
    logic                 start_rd;

    // On a tie the path opposite the previous grant wins (last_grant=1 means read went last).
    assign start_wr = (state_reg == IDLE) && wr_req && (!rd_req || last_grant);
    assign start_rd = (state_reg == IDLE) && rd_req && !start_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            aw_ready     <= 1'b0;
            ar_ready     <= 1'b0;
            grant_wr     <= 1'b0;
            grant_rd     <= 1'b0;
            last_grant   <= 1'b1;
            proto_err    <= 1'b0;
        end else begin
            aw_ready <= 1'b0;
            ar_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_beat || rd_beat)
                        proto_err <= 1'b1;
                    if (start_wr) begin
                        state_reg    <= WR;
                        beat_cnt_reg <= wr_len;
                        grant_wr     <= 1'b1;
                        aw_ready     <= 1'b1;
                        last_grant   <= 1'b0;
                    end else if (start_rd) begin
                        state_reg    <= RD;
                        beat_cnt_reg <= rd_len;
                        grant_rd     <= 1'b1;
                        ar_ready     <= 1'b1;
                        last_grant   <= 1'b1;
                    end
                end
                WR: begin
                    if (rd_beat)
                        proto_err <= 1'b1;
                    if (wr_beat) begin
                        if (beat_cnt_reg == '0) begin
                            state_reg <= TURN;
                            grant_wr  <= 1'b0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg - 1'b1;
                        end
                    end
                end
                RD: begin
                    if (wr_beat)
                        proto_err <= 1'b1;
                    if (rd_beat) begin
                        if (beat_cnt_reg == '0) begin
                            state_reg <= TURN;
                            grant_rd  <= 1'b0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    // TURN: one dead cycle between bursts; any beat here is unexpected.
                    if (wr_beat || rd_beat)
                        proto_err <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_RW_ARB_STATS_EN
    logic [1:0]            start_vec;
    logic [STAT_WIDTH-1:0] grant_cnt_reg [2];

    assign start_vec = {start_rd, start_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    grant_cnt_reg[gi] <= '0;
                else if (start_vec[gi] && (grant_cnt_reg[gi] != '1))
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign wr_grant_cnt = grant_cnt_reg[0];
    assign rd_grant_cnt = grant_cnt_reg[1];
`else
    assign wr_grant_cnt = '0;
    assign rd_grant_cnt = '0;
`endif

endmodule
